// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: shared opcodes, default width and the buffered result entry layout.
package alu_pkg;
    localparam int WIDTH = 4;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
        logic             err;
    } result_entry_t;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream operation/result bundle and downstream FIFO head handshake.
interface alu_result_stage_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       opCode;
    logic [WIDTH-1:0] add_Y;
    logic [WIDTH-1:0] sub_Y;
    logic             CarryOUT;
    logic             overflow;
    logic             chain_en;
    logic             chain_clr;
    logic             CarryChain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_Y;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;
    logic             out_err;
    logic [ERR_W-1:0] err_count;
    modport master (
        output in_valid, opCode, add_Y, sub_Y, CarryOUT, overflow, chain_en, chain_clr, out_ready,
        input  in_ready, CarryChain, out_valid, out_Y, out_carry, out_ovf, out_zero, out_neg,
               out_err, err_count
    );
    modport slave (
        input  in_valid, opCode, add_Y, sub_Y, CarryOUT, overflow, chain_en, chain_clr, out_ready,
        output in_ready, CarryChain, out_valid, out_Y, out_carry, out_ovf, out_zero, out_neg,
               out_err, err_count
    );
endinterface

// File: rtl/alu_result_stage_fifo.sv
// result_fifo: DEPTH-entry FIFO of result entries; head is read straight from storage.
module result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  result_entry_t wdata_i,
    output result_entry_t rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    result_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        full_o  = cnt_q == CW'(DEPTH);
        empty_o = cnt_q == '0;
        wr_d    = push_i ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = pop_i ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d   = cnt_q + CW'(push_i) - CW'(pop_i);
    end
    assign rdata_o = mem_q[rd_q];
    // Storage is cleared on reset so the head outputs read as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_i) mem_q[wr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: classifies add/sub results, buffers them with flags, chains carry and counts illegal ops.
module alu_result_stage #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_result_stage_if.slave bus
);
    alu_pkg::result_entry_t entry, head;
    logic             legal, push, pop, full, empty;
    logic [WIDTH-1:0] y;
    logic             carry_q, carry_d;
    logic [ERR_W-1:0] err_q, err_d;
    always_comb begin
        legal   = bus.opCode == alu_pkg::OP_ADD || bus.opCode == alu_pkg::OP_SUB;
        y       = bus.add_Y | bus.sub_Y;
        push    = bus.in_valid & ~full;
        pop     = ~empty & bus.out_ready;
        entry   = legal ? alu_pkg::result_entry_t'{y: y, carry: bus.CarryOUT, ovf: bus.overflow,
                                                   zero: y == '0, neg: y[WIDTH-1], err: 1'b0}
                        : alu_pkg::result_entry_t'{err: 1'b1, default: '0};
        carry_d = bus.chain_clr ? 1'b0 : (push & legal) ? bus.chain_en & bus.CarryOUT : carry_q;
        err_d   = (push & ~legal & ~&err_q) ? err_q + ERR_W'(1) : err_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            err_q   <= '0;
        end else begin
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end
    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(entry),
        .rdata_o(head),
        .full_o (full),
        .empty_o(empty)
    );
    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ~empty;
    assign bus.out_Y      = head.y;
    assign bus.out_carry  = head.carry;
    assign bus.out_ovf    = head.ovf;
    assign bus.out_zero   = head.zero;
    assign bus.out_neg    = head.neg;
    assign bus.out_err    = head.err;
    assign bus.CarryChain = carry_q;
    assign bus.err_count  = err_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vector table, FIFO corner sequences and random traffic against a queue model.
module tb_alu_result_stage;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    alu_result_stage_if #(.WIDTH(4), .ERR_W(8)) bus ();
    alu_result_stage #(.WIDTH(4), .DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    typedef struct {
        int op, a, s, co, ov, ce, cc;
        int ey, ec, eo, ez, en, ee, ech;
    } vec_t;
    vec_t vt[7];
    logic [8:0] mq[$];
    int m_chain, m_err;
    int n_checks = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [8:0] head_bits();
        return {bus.out_Y, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg, bus.out_err};
    endfunction
    function automatic logic [8:0] expect_entry(int op, int a, int s, int co, int ov);
        int y;
        if (op != 1 && op != 2) return 9'b1;
        y = (a | s) & 15;
        return {4'(y), co[0], ov[0], y == 0, y >= 8, 1'b0};
    endfunction
    task automatic cycle();
        bit push, pop, legal;
        push  = bus.in_valid && mq.size() < DEPTH;
        pop   = mq.size() > 0 && bus.out_ready;
        legal = bus.opCode == 2'b01 || bus.opCode == 2'b10;
        if (reset) begin
            mq.delete();
            m_chain = 0;
            m_err   = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(expect_entry(int'(bus.opCode), int'(bus.add_Y), int'(bus.sub_Y),
                                                int'(bus.CarryOUT), int'(bus.overflow)));
            if (bus.chain_clr) m_chain = 0;
            else if (push && legal) m_chain = bus.chain_en && bus.CarryOUT;
            if (push && !legal && m_err < 255) m_err++;
        end
        @(posedge clk);
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        chk("CarryChain", 32'(bus.CarryChain), m_chain);
        chk("err_count", 32'(bus.err_count), m_err);
        if (mq.size() > 0) chk("head", 32'(head_bits()), 32'(mq[0]));
    endtask
    initial begin
        vt[0] = '{1, 'hA, 0, 1, 0, 1, 0, 'hA, 1, 0, 0, 1, 0, 1};
        vt[1] = '{3, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[2] = '{0, 6, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[3] = '{2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[4] = '{1, 7, 0, 1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0};
        vt[5] = '{2, 0, 9, 1, 0, 1, 1, 9, 1, 0, 0, 1, 0, 0};
        vt[6] = '{1, 1, 2, 1, 1, 1, 0, 3, 1, 1, 0, 0, 0, 1};
        {bus.in_valid, bus.opCode, bus.add_Y, bus.sub_Y, bus.CarryOUT, bus.overflow} = '0;
        {bus.chain_en, bus.chain_clr, bus.out_ready} = '0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_chain", 32'(bus.CarryChain), 0);
        chk("idle_err", 32'(bus.err_count), 0);
        chk("idle_head", 32'(head_bits()), 0);
        for (int i = 0; i < 7; i++) begin
            bus.opCode    = 2'(vt[i].op);
            bus.add_Y     = 4'(vt[i].a);
            bus.sub_Y     = 4'(vt[i].s);
            bus.CarryOUT  = vt[i].co[0];
            bus.overflow  = vt[i].ov[0];
            bus.chain_en  = vt[i].ce[0];
            bus.chain_clr = vt[i].cc[0];
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            cycle();
            bus.in_valid  = 1'b0;
            bus.chain_clr = 1'b0;
            chk("vec_valid", 32'(bus.out_valid), 1);
            chk("vec_Y", 32'(bus.out_Y), vt[i].ey);
            chk("vec_carry", 32'(bus.out_carry), vt[i].ec);
            chk("vec_ovf", 32'(bus.out_ovf), vt[i].eo);
            chk("vec_zero", 32'(bus.out_zero), vt[i].ez);
            chk("vec_neg", 32'(bus.out_neg), vt[i].en);
            chk("vec_err", 32'(bus.out_err), vt[i].ee);
            chk("vec_chain", 32'(bus.CarryChain), vt[i].ech);
            if (i == 1) chk("err_one", 32'(bus.err_count), 1);
            bus.out_ready = 1'b1;
            cycle();
            bus.out_ready = 1'b0;
        end
        bus.chain_clr = 1'b1;
        cycle();
        bus.chain_clr = 1'b0;
        chk("clr_no_push", 32'(bus.CarryChain), 0);
        // Fill to full, hold a third op, release one slot, then reset with two entries resident.
        {bus.opCode, bus.CarryOUT, bus.chain_en, bus.sub_Y, bus.in_valid} = {2'b01, 1'b1, 1'b1, 4'h0, 1'b1};
        bus.add_Y = 4'h1;
        cycle();
        bus.add_Y = 4'h2;
        cycle();
        chk("full_in_ready", 32'(bus.in_ready), 0);
        bus.add_Y = 4'h3;
        repeat (2) cycle();
        chk("full_hold_Y", 32'(bus.out_Y), 1);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        chk("after_pop_Y", 32'(bus.out_Y), 2);
        chk("after_pop_ready", 32'(bus.in_ready), 1);
        cycle();
        bus.in_valid = 1'b0;
        chk("refull_ready", 32'(bus.in_ready), 0);
        chk("refull_chain", 32'(bus.CarryChain), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_chain", 32'(bus.CarryChain), 0);
        chk("rst_head", 32'(head_bits()), 0);
        {bus.opCode, bus.in_valid, bus.out_ready} = {2'b11, 1'b1, 1'b1};
        repeat (256) cycle();
        chk("err_sat", 32'(bus.err_count), 'hFF);
        repeat (4) cycle();
        chk("err_hold", 32'(bus.err_count), 'hFF);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (600) begin
            reset         = $urandom_range(0, 59) == 0;
            bus.in_valid  = 1'($urandom);
            bus.opCode    = 2'($urandom);
            bus.add_Y     = 4'($urandom);
            bus.sub_Y     = 4'($urandom);
            bus.CarryOUT  = 1'($urandom);
            bus.overflow  = 1'($urandom);
            bus.chain_en  = 1'($urandom);
            bus.chain_clr = $urandom_range(0, 7) == 0;
            bus.out_ready = 1'($urandom);
            cycle();
        end
        {reset, bus.in_valid, bus.chain_clr, bus.out_ready} = 4'b0001;
        repeat (4) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
